dkong3_vram_arb: RTL and testbench

DKONG3_VRAM_ARB -- requirements
Module: dkong3_vram_arb

---
 rtl/dkong3_vram_arb_if.sv | 35 +++
 rtl/dkong3_vram_arb.sv | 129 ++++++++++++
 tb/tb_dkong3_vram_arb.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/dkong3_vram_arb_if.sv
// Bus bundle between the CPU/video timing side and the VRAM arbiter.
// The arbiter sits on the slave modport; the stimulus/CPU side uses master.
interface dkong3_vram_arb_if;
    logic       I_VRAM_RDn;
    logic       I_VRAM_WRn;
    logic [9:0] I_AB;
    logic [7:0] I_DB;
    logic       I_CMPBLK;
    logic       I_FLIP;
    logic [9:0] I_H_CNT;
    logic [7:0] I_VF_CNT;
    logic [7:0] I_RAM_DQ;
    logic [9:0] O_RAM_AB;
    logic       O_RAM_CE;
    logic       O_RAM_WE;
    logic [7:0] O_RAM_D;
    logic [7:0] O_DB;
    logic       O_WAITn;
    logic       O_ABORT;
    logic [3:0] O_ABORT_CNT;

    modport slave (
        input  I_VRAM_RDn, I_VRAM_WRn, I_AB, I_DB, I_CMPBLK, I_FLIP,
               I_H_CNT, I_VF_CNT, I_RAM_DQ,
        output O_RAM_AB, O_RAM_CE, O_RAM_WE, O_RAM_D, O_DB, O_WAITn,
               O_ABORT, O_ABORT_CNT
    );

    modport master (
        output I_VRAM_RDn, I_VRAM_WRn, I_AB, I_DB, I_CMPBLK, I_FLIP,
               I_H_CNT, I_VF_CNT, I_RAM_DQ,
        input  O_RAM_AB, O_RAM_CE, O_RAM_WE, O_RAM_D, O_DB, O_WAITn,
               O_ABORT, O_ABORT_CNT
    );
endinterface

// File: rtl/dkong3_vram_arb.sv
// Video RAM arbiter: the video scanner owns VRAM while I_CMPBLK=0, the CPU
// gets a two-cycle access window (ACC1 address/write, ACC2 read data) during
// blank. A CPU access cut short by the end of blank is retried from ACC1 on
// the next blank using the latched address/data.
module dkong3_vram_arb (
    input  logic               I_CLK_24M,
    input  logic               I_RESET,
    dkong3_vram_arb_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PEND = 3'd1,
        ST_ACC1 = 3'd2,
        ST_ACC2 = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t     state_reg;
    logic [9:0] addr_reg;
    logic [7:0] data_reg;
    logic       is_wr_reg;
    logic [7:0] db_reg;
    logic       abort_reg;
    logic [3:0] abort_cnt_reg;

    logic       req;
    logic       in_acc;
    logic       grant;
    logic [4:0] h_flip;
    logic [9:0] video_ab;
    logic       unused_cnt_bits;

    assign req    = !bus.I_VRAM_RDn || !bus.I_VRAM_WRn;
    assign in_acc = (state_reg == ST_ACC1) || (state_reg == ST_ACC2);
    // The CPU only drives the RAM while blank is up; ownership flips back to
    // video combinationally the moment blank drops, and reset kills it too.
    assign grant  = in_acc && bus.I_CMPBLK && !I_RESET;

    // Horizontal tile column, mirrored when the screen is flipped.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_hflip
            assign h_flip[gi] = bus.I_H_CNT[4 + gi] ^ bus.I_FLIP;
        end
    endgenerate

    assign video_ab = {bus.I_VF_CNT[7:3], h_flip};

    // Counter bits below tile granularity are not needed for addressing.
    assign unused_cnt_bits = ^{bus.I_H_CNT[9], bus.I_H_CNT[3:0], bus.I_VF_CNT[2:0]};

    assign bus.O_RAM_AB    = in_acc ? addr_reg : video_ab;
    assign bus.O_RAM_CE    = grant;
    assign bus.O_RAM_WE    = grant && (state_reg == ST_ACC1) && is_wr_reg;
    assign bus.O_RAM_D     = data_reg;
    assign bus.O_DB        = db_reg;
    assign bus.O_ABORT     = abort_reg;
    assign bus.O_ABORT_CNT = abort_cnt_reg;
    // Wait goes low in the very cycle a request appears in IDLE, so the CPU
    // never samples a ready before the arbiter has latched its access.
    assign bus.O_WAITn     = I_RESET ? 1'b1 :
                             !(((state_reg == ST_IDLE) && req) ||
                               (state_reg == ST_PEND) || in_acc);

    // Access sequencer with latched request and registered status outputs.
    always_ff @(posedge I_CLK_24M) begin
        if (I_RESET) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= 10'h000;
            data_reg      <= 8'h00;
            is_wr_reg     <= 1'b0;
            db_reg        <= 8'h00;
            abort_reg     <= 1'b0;
            abort_cnt_reg <= 4'h0;
        end else begin
            abort_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        addr_reg  <= bus.I_AB;
                        data_reg  <= bus.I_DB;
                        is_wr_reg <= !bus.I_VRAM_WRn;
                        state_reg <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (bus.I_CMPBLK) begin
                        state_reg <= ST_ACC1;
                    end
                end
                ST_ACC1: begin
                    if (bus.I_CMPBLK) begin
                        state_reg <= ST_ACC2;
                    end else begin
                        state_reg <= ST_PEND;
                        abort_reg <= 1'b1;
                        if (abort_cnt_reg != 4'hF) begin
                            abort_cnt_reg <= abort_cnt_reg + 4'd1;
                        end
                    end
                end
                ST_ACC2: begin
                    if (bus.I_CMPBLK) begin
                        state_reg <= ST_DONE;
                        if (!is_wr_reg) begin
                            db_reg <= bus.I_RAM_DQ;
                        end
                    end else begin
                        state_reg <= ST_PEND;
                        abort_reg <= 1'b1;
                        if (abort_cnt_reg != 4'hF) begin
                            abort_cnt_reg <= abort_cnt_reg + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    // Hold here until the CPU lets go so one strobe = one access.
                    if (bus.I_VRAM_RDn && bus.I_VRAM_WRn) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dkong3_vram_arb.sv
// Directed bench for the VRAM arbiter: a per-cycle vector table for the
// basic write/read/dual-strobe flows, then hand sequences for preemption,
// abort-count saturation, a held strobe, and reset in the middle of a write.
module tb_dkong3_vram_arb;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    dkong3_vram_arb_if bus();

    dkong3_vram_arb dut (
        .I_CLK_24M (clk),
        .I_RESET   (rst),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       rdn;
        logic       wrn;
        logic [9:0] ab;
        logic [7:0] db;
        logic       cmp;
        logic       flip;
        logic [7:0] dq;
        logic [9:0] e_ab;
        logic       e_ce;
        logic       e_we;
        logic [7:0] e_d;
        logic [7:0] e_odb;
        logic       e_waitn;
        logic       e_abort;
        logic [3:0] e_cnt;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // One clock cycle: drive just after the rising edge, settle to the falling edge.
    task automatic cyc(input logic r, input logic rdn, input logic wrn, input logic [9:0] ab,
                       input logic [7:0] db, input logic cmp, input logic flip, input logic [7:0] dq);
        @(posedge clk);
        #1;
        rst            = r;
        bus.I_VRAM_RDn = rdn;
        bus.I_VRAM_WRn = wrn;
        bus.I_AB       = ab;
        bus.I_DB       = db;
        bus.I_CMPBLK   = cmp;
        bus.I_FLIP     = flip;
        bus.I_RAM_DQ   = dq;
        @(negedge clk);
    endtask

    initial begin
        int ce_cnt;
        int we_cnt;
        errors = 0;
        checks = 0;
        // Video counters fixed: tile addr 10'h12A unflipped, 10'h135 flipped.
        bus.I_H_CNT    = 10'h0A0;
        bus.I_VF_CNT   = 8'h48;
        rst            = 1'b1;
        bus.I_VRAM_RDn = 1'b1;
        bus.I_VRAM_WRn = 1'b1;
        bus.I_AB       = 10'h000;
        bus.I_DB       = 8'h00;
        bus.I_CMPBLK   = 1'b1;
        bus.I_FLIP     = 1'b0;
        bus.I_RAM_DQ   = 8'h00;

        //           rst   rdn   wrn   ab       db     cmp   flip  dq     | e_ab    ce    we    d      odb    waitn abort cnt
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1, 1'b0, 8'h00, 10'h12A, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 4'd0};
        // write 0xA5 to 0x155 during blank
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 10'h155, 8'hA5, 1'b1, 1'b0, 8'h00, 10'h12A, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 10'h155, 8'hA5, 1'b1, 1'b0, 8'h00, 10'h12A, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 10'h155, 8'hA5, 1'b1, 1'b0, 8'h00, 10'h155, 1'b1, 1'b1, 8'hA5, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 10'h155, 8'hA5, 1'b1, 1'b0, 8'h00, 10'h155, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 10'h155, 8'hA5, 1'b1, 1'b0, 8'h00, 10'h12A, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b0, 4'd0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 10'h155, 8'hA5, 1'b1, 1'b0, 8'h00, 10'h12A, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b0, 4'd0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 10'h155, 8'hA5, 1'b1, 1'b0, 8'h00, 10'h12A, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b0, 4'd0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 10'h155, 8'hA5, 1'b1, 1'b1, 8'h00, 10'h135, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b0, 4'd0};
        // read of 0x2C3 requested during display, RAM returns 0x3C
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 10'h2C3, 8'h11, 1'b0, 1'b1, 8'h3C, 10'h135, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 10'h2C3, 8'h11, 1'b0, 1'b1, 8'h3C, 10'h135, 1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 10'h2C3, 8'h11, 1'b0, 1'b0, 8'h3C, 10'h12A, 1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 10'h2C3, 8'h11, 1'b1, 1'b0, 8'h3C, 10'h12A, 1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 10'h2C3, 8'h11, 1'b1, 1'b0, 8'h3C, 10'h2C3, 1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 10'h2C3, 8'h11, 1'b1, 1'b0, 8'h3C, 10'h2C3, 1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 10'h2C3, 8'h11, 1'b1, 1'b0, 8'h3C, 10'h12A, 1'b0, 1'b0, 8'h11, 8'h3C, 1'b1, 1'b0, 4'd0};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 10'h2C3, 8'h11, 1'b1, 1'b0, 8'h00, 10'h12A, 1'b0, 1'b0, 8'h11, 8'h3C, 1'b1, 1'b0, 4'd0};
        // both strobes low -> write 0x81 to 0x0F0; strobe changes in PEND/ACC ignored
        tbl[17] = '{1'b0, 1'b0, 1'b0, 10'h0F0, 8'h81, 1'b1, 1'b0, 8'hEE, 10'h12A, 1'b0, 1'b0, 8'h11, 8'h3C, 1'b0, 1'b0, 4'd0};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 10'h0F0, 8'h81, 1'b1, 1'b0, 8'hEE, 10'h12A, 1'b0, 1'b0, 8'h81, 8'h3C, 1'b0, 1'b0, 4'd0};
        tbl[19] = '{1'b0, 1'b1, 1'b1, 10'h0F0, 8'h81, 1'b1, 1'b0, 8'hEE, 10'h0F0, 1'b1, 1'b1, 8'h81, 8'h3C, 1'b0, 1'b0, 4'd0};
        tbl[20] = '{1'b0, 1'b1, 1'b1, 10'h0F0, 8'h81, 1'b1, 1'b0, 8'hEE, 10'h0F0, 1'b1, 1'b0, 8'h81, 8'h3C, 1'b0, 1'b0, 4'd0};
        tbl[21] = '{1'b0, 1'b1, 1'b1, 10'h0F0, 8'h81, 1'b1, 1'b0, 8'hEE, 10'h12A, 1'b0, 1'b0, 8'h81, 8'h3C, 1'b1, 1'b0, 4'd0};
        tbl[22] = '{1'b0, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1, 1'b0, 8'hEE, 10'h12A, 1'b0, 1'b0, 8'h81, 8'h3C, 1'b1, 1'b0, 4'd0};

        cyc(1'b1, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1, 1'b0, 8'h00);

        for (int i = 0; i < NV; i++) begin
            cyc(tbl[i].rst, tbl[i].rdn, tbl[i].wrn, tbl[i].ab, tbl[i].db,
                tbl[i].cmp, tbl[i].flip, tbl[i].dq);
            chk("ram_ab",    i, 16'(bus.O_RAM_AB),    16'(tbl[i].e_ab));
            chk("ram_ce",    i, 16'(bus.O_RAM_CE),    16'(tbl[i].e_ce));
            chk("ram_we",    i, 16'(bus.O_RAM_WE),    16'(tbl[i].e_we));
            chk("ram_d",     i, 16'(bus.O_RAM_D),     16'(tbl[i].e_d));
            chk("db",        i, 16'(bus.O_DB),        16'(tbl[i].e_odb));
            chk("waitn",     i, 16'(bus.O_WAITn),     16'(tbl[i].e_waitn));
            chk("abort",     i, 16'(bus.O_ABORT),     16'(tbl[i].e_abort));
            chk("abort_cnt", i, 16'(bus.O_ABORT_CNT), 16'(tbl[i].e_cnt));
            $display("step %0d: ab=%h ce=%b we=%b d=%h db=%h waitn=%b abort=%b cnt=%0d",
                     i, bus.O_RAM_AB, bus.O_RAM_CE, bus.O_RAM_WE, bus.O_RAM_D,
                     bus.O_DB, bus.O_WAITn, bus.O_ABORT, bus.O_ABORT_CNT);
        end

        // Preemption in ACC2 of a write of 0x5A to 0x077.
        cyc(1'b0, 1'b1, 1'b0, 10'h077, 8'h5A, 1'b1, 1'b0, 8'h00);   // IDLE
        cyc(1'b0, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1, 1'b0, 8'h00);   // PEND
        cyc(1'b0, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1, 1'b0, 8'h00);   // ACC1
        chk("pre_acc1_we", 100, 16'(bus.O_RAM_WE), 16'd1);
        cyc(1'b0, 1'b1, 1'b1, 10'h000, 8'h00, 1'b0, 1'b0, 8'h00);   // ACC2, blank drops
        chk("pre_acc2_ce", 101, 16'(bus.O_RAM_CE), 16'd0);
        chk("pre_acc2_abort", 101, 16'(bus.O_ABORT), 16'd0);
        cyc(1'b0, 1'b1, 1'b1, 10'h000, 8'h00, 1'b0, 1'b0, 8'h00);   // back in PEND
        chk("pre_abort", 102, 16'(bus.O_ABORT), 16'd1);
        chk("pre_cnt", 102, 16'(bus.O_ABORT_CNT), 16'd1);
        chk("pre_waitn", 102, 16'(bus.O_WAITn), 16'd0);
        chk("pre_ab_video", 102, 16'(bus.O_RAM_AB), 16'h12A);
        $display("preempt: abort=%b cnt=%0d", bus.O_ABORT, bus.O_ABORT_CNT);
        cyc(1'b0, 1'b1, 1'b1, 10'h000, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("pre_abort_end", 103, 16'(bus.O_ABORT), 16'd0);

        // Abort repeatedly in ACC1: count saturates at 15 after 16 aborts.
        for (int k = 2; k <= 16; k++) begin
            cyc(1'b0, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1, 1'b0, 8'h00);   // PEND -> ACC1
            chk("sat_pend_abort", k, 16'(bus.O_ABORT), 16'd0);
            cyc(1'b0, 1'b1, 1'b1, 10'h000, 8'h00, 1'b0, 1'b0, 8'h00);   // ACC1 preempted
            chk("sat_we", k, 16'(bus.O_RAM_WE), 16'd0);
            cyc(1'b0, 1'b1, 1'b1, 10'h000, 8'h00, 1'b0, 1'b0, 8'h00);   // PEND
            chk("sat_abort", k, 16'(bus.O_ABORT), 16'd1);
            chk("sat_cnt", k, 16'(bus.O_ABORT_CNT), 16'((k > 15) ? 15 : k));
            $display("abort %0d: cnt=%0d", k, bus.O_ABORT_CNT);
        end

        // Retry completes on the next blank with the latched address/data.
        cyc(1'b0, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1, 1'b0, 8'h00);       // PEND
        cyc(1'b0, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1, 1'b0, 8'h00);       // ACC1
        chk("retry_ab", 110, 16'(bus.O_RAM_AB), 16'h077);
        chk("retry_we", 110, 16'(bus.O_RAM_WE), 16'd1);
        chk("retry_d", 110, 16'(bus.O_RAM_D), 16'h5A);
        cyc(1'b0, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1, 1'b0, 8'h00);       // ACC2
        cyc(1'b0, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1, 1'b0, 8'h00);       // DONE
        chk("retry_waitn", 111, 16'(bus.O_WAITn), 16'd1);
        chk("retry_cnt", 111, 16'(bus.O_ABORT_CNT), 16'd15);
        $display("retry: waitn=%b cnt=%0d", bus.O_WAITn, bus.O_ABORT_CNT);
        cyc(1'b0, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1, 1'b0, 8'h00);       // IDLE

        // Held read strobe: 4 cycles to DONE then 10 more with RDn still low.
        ce_cnt = 0;
        we_cnt = 0;
        for (int c = 0; c < 14; c++) begin
            cyc(1'b0, 1'b0, 1'b1, 10'h3A5, 8'h44, 1'b1, 1'b0, 8'h96);
            if (bus.O_RAM_CE) ce_cnt++;
            if (bus.O_RAM_WE) we_cnt++;
        end
        chk("held_ce_cycles", 120, 16'(ce_cnt), 16'd2);
        chk("held_we_cycles", 120, 16'(we_cnt), 16'd0);
        chk("held_db", 120, 16'(bus.O_DB), 16'h96);
        chk("held_waitn", 120, 16'(bus.O_WAITn), 16'd1);
        $display("held strobe: ce_cycles=%0d db=%h", ce_cnt, bus.O_DB);
        cyc(1'b0, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1, 1'b0, 8'h00);       // DONE -> IDLE
        cyc(1'b0, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1, 1'b0, 8'h00);       // IDLE
        chk("held_idle_waitn", 121, 16'(bus.O_WAITn), 16'd1);

        // Reset asserted during ACC1 of a write.
        cyc(1'b0, 1'b1, 1'b0, 10'h1FF, 8'hC3, 1'b1, 1'b0, 8'h00);       // IDLE
        cyc(1'b0, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1, 1'b0, 8'h00);       // PEND
        cyc(1'b1, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1, 1'b0, 8'h00);       // ACC1 + reset
        chk("rst_acc1_we", 130, 16'(bus.O_RAM_WE), 16'd0);
        chk("rst_acc1_ce", 130, 16'(bus.O_RAM_CE), 16'd0);
        chk("rst_acc1_waitn", 130, 16'(bus.O_WAITn), 16'd1);
        cyc(1'b0, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1, 1'b0, 8'h00);
        chk("rst_waitn", 131, 16'(bus.O_WAITn), 16'd1);
        chk("rst_cnt", 131, 16'(bus.O_ABORT_CNT), 16'd0);
        chk("rst_abort", 131, 16'(bus.O_ABORT), 16'd0);
        chk("rst_d", 131, 16'(bus.O_RAM_D), 16'h00);
        chk("rst_db", 131, 16'(bus.O_DB), 16'h00);
        chk("rst_ab", 131, 16'(bus.O_RAM_AB), 16'h12A);
        $display("reset in ACC1: waitn=%b cnt=%0d d=%h", bus.O_WAITn, bus.O_ABORT_CNT, bus.O_RAM_D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
